// File: rtl/cache_mux_types.sv
// Shared types for the cache-to-memory muxing blocks.
`timescale 1ns/1ps
package cache_mux_types;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_owner_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP   = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter serializing I-cache fills and D-cache fills/writebacks
// onto one line-granular memory port; request, address, wdata and line are registered.
`timescale 1ns/1ps
module pmem_arbiter
    import cache_mux_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state, state_nxt;
    arb_owner_t        owner, last_grant;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_buf;
    logic              d_req;
    logic              grant_i, grant_d;
    logic              busy;

    assign d_req = d_pmem_read | d_pmem_write;
    assign busy  = (state == BUSY_I) || (state == BUSY_D);

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, the side that did not win last time goes first.
                if (i_pmem_read && d_req) begin
                    if (last_grant == ARB_D) grant_i = 1'b1;
                    else                     grant_d = 1'b1;
                end else if (i_pmem_read) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i)      state_nxt = BUSY_I;
                else if (grant_d) state_nxt = BUSY_D;
            end
            BUSY_I, BUSY_D: if (mem_resp) state_nxt = RESP;
            RESP:           state_nxt = DONE;
            DONE:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= ARB_I;
            last_grant <= ARB_D;
            op_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_buf   <= '0;
        end else begin
            if (grant_i) begin
                owner      <= ARB_I;
                last_grant <= ARB_I;
                op_write   <= 1'b0;
                addr_q     <= i_pmem_address;
            end else if (grant_d) begin
                owner      <= ARB_D;
                last_grant <= ARB_D;
                op_write   <= d_pmem_write;
                addr_q     <= d_pmem_address;
                wdata_q    <= d_pmem_wdata;
            end
            if (busy && mem_resp) line_buf <= mem_rdata;
        end
    end

    // Strobes decode from the state register only, so reset clears them immediately.
    assign mem_read     = (state == BUSY_I) || ((state == BUSY_D) && !op_write);
    assign mem_write    = (state == BUSY_D) && op_write;
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;
    assign i_pmem_resp  = (state == RESP) && (owner == ARB_I);
    assign d_pmem_resp  = (state == RESP) && (owner == ARB_D);
    assign i_pmem_rdata = line_buf;
    assign d_pmem_rdata = line_buf;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: directed requests push expectations, monitors pop on output events.
`timescale 1ns/1ps
module tb_pmem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef struct {
        bit                is_d;
        bit                chk;
        logic [LINE_W-1:0] data;
    } resp_t;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                len;
    } op_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_pmem_read = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0;
    logic              d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int    compared = 0;
    int    errors   = 0;
    int    resp_seen = 0;
    int    lat = 1;
    int    stray_req = 0;
    resp_t exp_resp[$];
    op_t   exp_op[$];

    pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] line_for(input logic [ADDR_W-1:0] a);
        if (a == 32'h0000_1240) return {32{8'hA5}};
        return {8{~a}};
    endfunction

    // Memory model: answers after lat cycles of a held strobe; stray pulses on request.
    initial begin
        int cnt = 0;
        int stray_done = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            if (!rst) begin
                cnt = 0;
            end else if (stray_req != stray_done) begin
                stray_done = stray_req;
                mem_resp   = 1'b1;
                mem_rdata  = {LINE_W{1'b1}};
            end else if (mem_read || mem_write) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = line_for(mem_address);
                    cnt       = 0;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (i_pmem_resp || d_pmem_resp) begin
                resp_seen++;
                compared++;
                if (exp_resp.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got i=%0b d=%0b, required no resp", i_pmem_resp, d_pmem_resp);
                end else begin
                    e = exp_resp.pop_front();
                    if (i_pmem_resp == e.is_d || d_pmem_resp != e.is_d) begin
                        errors++;
                        $display("FAIL resp_owner: got i=%0b d=%0b, required d=%0b", i_pmem_resp, d_pmem_resp, e.is_d);
                    end else if (e.chk && (e.is_d ? d_pmem_rdata : i_pmem_rdata) != e.data) begin
                        errors++;
                        $display("FAIL resp_data: got %h, required %h", e.is_d ? d_pmem_rdata : i_pmem_rdata, e.data);
                    end
                end
            end
        end
    end

    // Memory-side monitor: one expected op per strobe burst, burst length checked at its end.
    initial begin
        op_t cur;
        bit  prev_act = 1'b0;
        bit  act;
        int  blen = 0;
        cur = '{wr: 1'b0, addr: '0, wdata: '0, len: 0};
        forever begin
            @(negedge clk);
            act = mem_read | mem_write;
            if (act && !prev_act) begin
                compared++;
                if (exp_op.size() == 0) begin
                    errors++;
                    $display("FAIL op_unexpected: got rd=%0b wr=%0b addr=%h, required none", mem_read, mem_write, mem_address);
                    cur.len = 0;
                end else begin
                    cur = exp_op.pop_front();
                    if (mem_read != !cur.wr || mem_write != cur.wr || mem_address != cur.addr ||
                        (cur.wr && mem_wdata != cur.wdata)) begin
                        errors++;
                        $display("FAIL op_start: got rd=%0b wr=%0b addr=%h wdata=%h, required wr=%0b addr=%h wdata=%h",
                                 mem_read, mem_write, mem_address, mem_wdata, cur.wr, cur.addr, cur.wdata);
                    end
                end
                blen = 0;
            end
            if (act) blen++;
            if (!act && prev_act && cur.len != 0) begin
                compared++;
                if (blen != cur.len) begin
                    errors++;
                    $display("FAIL op_len: got %0d cycles, required %0d", blen, cur.len);
                end
            end
            prev_act = act;
        end
    end

    task automatic req_i(input logic [ADDR_W-1:0] a, input bit late);
        int n = 0;
        i_pmem_address = a;
        i_pmem_read    = 1'b1;
        do begin @(posedge clk); #2; n++; end while (!i_pmem_resp && n < 200);
        if (!i_pmem_resp) begin
            compared++; errors++;
            $display("FAIL i_timeout: got no i_pmem_resp in %0d cycles, required a resp", n);
        end
        if (late) begin
            @(posedge clk); #2;
            @(posedge clk); #2;
        end
        i_pmem_read = 1'b0;
    endtask

    task automatic req_d(input bit wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd, input bit late);
        int n = 0;
        d_pmem_address = a;
        d_pmem_wdata   = wd;
        d_pmem_read    = !wr;
        d_pmem_write   = wr;
        do begin @(posedge clk); #2; n++; end while (!d_pmem_resp && n < 200);
        if (!d_pmem_resp) begin
            compared++; errors++;
            $display("FAIL d_timeout: got no d_pmem_resp in %0d cycles, required a resp", n);
        end
        if (late) begin
            @(posedge clk); #2;
            @(posedge clk); #2;
        end
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        int seen0;

        // Reset held with toggling cache inputs: every output stays 0.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #2;
            i_pmem_read    = 1'($urandom);
            i_pmem_address = $urandom;
            d_pmem_read    = 1'($urandom);
            d_pmem_write   = !d_pmem_read && 1'($urandom);
            d_pmem_address = $urandom;
            d_pmem_wdata   = {8{32'($urandom)}};
            @(negedge clk);
            compared++;
            if ({i_pmem_rdata, d_pmem_rdata, mem_address, mem_wdata,
                 i_pmem_resp, d_pmem_resp, mem_read, mem_write} != '0) begin
                errors++;
                $display("FAIL reset_outputs: got rd=%0b wr=%0b ir=%0b dr=%0b addr=%h, required all 0",
                         mem_read, mem_write, i_pmem_resp, d_pmem_resp, mem_address);
            end
        end
        @(posedge clk); #2;
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            compared++;
            if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} != 4'b0) begin
                errors++;
                $display("FAIL idle_after_reset: got rd=%0b wr=%0b ir=%0b dr=%0b, required 0",
                         mem_read, mem_write, i_pmem_resp, d_pmem_resp);
            end
        end

        // Single I-fill, memory latency 3.
        idle_cycles(1);
        lat = 3;
        exp_op.push_back('{wr: 1'b0, addr: 32'h0000_1240, wdata: '0, len: 3});
        exp_resp.push_back('{is_d: 1'b0, chk: 1'b1, data: {32{8'hA5}}});
        req_i(32'h0000_1240, 1'b0);

        // D writeback, latency 2.
        idle_cycles(3);
        lat = 2;
        exp_op.push_back('{wr: 1'b1, addr: 32'h8000_0020, wdata: {16{16'h1234}}, len: 2});
        exp_resp.push_back('{is_d: 1'b1, chk: 1'b0, data: '0});
        req_d(1'b1, 32'h8000_0020, {16{16'h1234}}, 1'b0);

        // Fresh reset, then a tie: I first, D second.
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(1);
        rst = 1'b1;
        idle_cycles(1);
        lat = 1;
        exp_op.push_back('{wr: 1'b0, addr: 32'h0000_0100, wdata: '0, len: 1});
        exp_op.push_back('{wr: 1'b0, addr: 32'h0000_0200, wdata: '0, len: 1});
        exp_resp.push_back('{is_d: 1'b0, chk: 1'b1, data: {8{32'hFFFF_FEFF}}});
        exp_resp.push_back('{is_d: 1'b1, chk: 1'b1, data: {8{32'hFFFF_FDFF}}});
        fork
            req_i(32'h0000_0100, 1'b0);
            req_d(1'b0, 32'h0000_0200, '0, 1'b0);
        join

        // Lone I fill held through the cycle after resp: exactly one burst.
        idle_cycles(3);
        lat = 2;
        exp_op.push_back('{wr: 1'b0, addr: 32'h0000_0400, wdata: '0, len: 2});
        exp_resp.push_back('{is_d: 1'b0, chk: 1'b1, data: {8{32'hFFFF_FBFF}}});
        req_i(32'h0000_0400, 1'b1);

        // Last grant was I, so the next tie goes to D first.
        idle_cycles(3);
        lat = 1;
        exp_op.push_back('{wr: 1'b0, addr: 32'h0000_0280, wdata: '0, len: 1});
        exp_op.push_back('{wr: 1'b0, addr: 32'h0000_0140, wdata: '0, len: 1});
        exp_resp.push_back('{is_d: 1'b1, chk: 1'b1, data: {8{32'hFFFF_FD7F}}});
        exp_resp.push_back('{is_d: 1'b0, chk: 1'b1, data: {8{32'hFFFF_FEBF}}});
        fork
            req_i(32'h0000_0140, 1'b1);
            req_d(1'b0, 32'h0000_0280, '0, 1'b1);
        join

        // Reset in the middle of a D read; a stray mem_resp afterwards is ignored.
        idle_cycles(3);
        lat = 20;
        exp_op.push_back('{wr: 1'b0, addr: 32'h0000_0300, wdata: '0, len: 0});
        d_pmem_address = 32'h0000_0300;
        d_pmem_read    = 1'b1;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!mem_read && n < 50);
        compared++;
        if (!mem_read) begin
            errors++;
            $display("FAIL abort_grant: got mem_read=0 after %0d cycles, required 1", n);
        end
        idle_cycles(2);
        #1;
        seen0 = resp_seen;
        rst = 1'b0;
        #1;
        compared++;
        if (mem_read || mem_write) begin
            errors++;
            $display("FAIL abort_drop: got rd=%0b wr=%0b, required 0 immediately", mem_read, mem_write);
        end
        d_pmem_read = 1'b0;
        idle_cycles(2);
        rst = 1'b1;
        lat = 1;
        idle_cycles(1);
        stray_req++;
        idle_cycles(6);
        compared++;
        if (resp_seen != seen0) begin
            errors++;
            $display("FAIL stray_resp: got %0d resp pulses, required 0", resp_seen - seen0);
        end

        idle_cycles(5);
        compared++;
        if (exp_resp.size() != 0 || exp_op.size() != 0) begin
            errors++;
            $display("FAIL leftovers: got %0d resp / %0d op still expected, required 0 / 0",
                     exp_resp.size(), exp_op.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns, required finish");
        $fatal(1);
    end

endmodule
